can_bitstuffer: RTL and testbench

Bit-stream stage sitting directly above the CAN quanta sampler. It consumes the sampler's per-slot received bit, contamination flag and sample-valid strobe, and drives the sampler's transmit-bit input. Toward the frame layer it presents an unstuffed TX bit handshake and an unstuffed RX bit stream. It handles stuff-bit insertion and removal, stuff-error detection, arbitration-loss detection and bit-error detection.

---
 rtl/can_bitstuffer.sv | 203 ++++++++++++++++++++
 tb/tb_can_bitstuffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bitstuffer.sv
// can_bitstuffer
// Bit-stream stage between the CAN quanta sampler and the frame layer.
// On each sample event it removes stuff bits from the received stream,
// checks them, and chooses the next transmitted bit (data, stuff or
// recessive). It also flags arbitration loss and bit errors.
// Every state change happens on the sample cycle. All outputs are
// registered, so they appear one clock after the sample event.

module can_bitstuffer #(
  parameter int STUFF_LEN = 5
) (
  input  logic GCLK,
  input  logic RES,
  input  logic dout,
  input  logic cntmn,
  input  logic cntmn_ready,
  output logic din,
  input  logic stuff_en,
  input  logic arb_en,
  input  logic tx_valid,
  input  logic tx_bit,
  output logic tx_ready,
  output logic tx_busy,
  output logic rx_valid,
  output logic rx_bit,
  output logic stuff_err,
  output logic arb_lost,
  output logic bit_err
);

  // TX FSM encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_LOST   = 2'd2;

  localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

  // sample-event detection
  logic       cntmn_ready_q;
  logic       samp;

  // run tracking on the bus stream
  logic [2:0] count;
  logic [2:0] count_nx;
  logic       last;
  logic       last_nx;
  logic       pending;
  logic       pending_nx;

  // TX FSM
  logic [1:0] state;
  logic [1:0] state_nx;

  // next values of the registered outputs
  logic       din_nx;
  logic       tx_ready_nx;
  logic       rx_valid_nx;
  logic       rx_bit_nx;
  logic       stuff_err_nx;
  logic       arb_lost_nx;
  logic       bit_err_nx;

  // result of the "load next bit" decision
  logic       load_din;
  logic       load_take;
  logic       load_stuff;

  assign samp    = cntmn_ready & ~cntmn_ready_q;
  assign tx_busy = (state != S_IDLE);

  // RX side: destuff, check stuff bits, and update the run of identical bus bits
  always_comb begin
    count_nx     = count;
    last_nx      = last;
    pending_nx   = pending;
    rx_valid_nx  = 1'b0;
    rx_bit_nx    = rx_bit;
    stuff_err_nx = 1'b0;
    if (!stuff_en) begin
      count_nx    = 3'd0;
      pending_nx  = 1'b0;
      rx_valid_nx = 1'b1;
      rx_bit_nx   = dout;
    end else if (pending) begin
      stuff_err_nx = (dout == last);
      count_nx     = 3'd1;
      last_nx      = dout;
      pending_nx   = 1'b0;
    end else begin
      rx_valid_nx = 1'b1;
      rx_bit_nx   = dout;
      if (count != 3'd0 && dout == last) begin
        count_nx = (count == RUN_MAX) ? RUN_MAX : count + 3'd1;
      end else begin
        count_nx = 3'd1;
      end
      last_nx    = dout;
      pending_nx = (count_nx == RUN_MAX);
    end
  end

  // Choose the next transmitted bit. A due stuff bit takes precedence
  // over frame data; with nothing to send the bus stays recessive.
  always_comb begin
    load_stuff = 1'b0;
    load_take  = 1'b0;
    load_din   = 1'b1;
    if (stuff_en && pending_nx) begin
      load_stuff = 1'b1;
      load_din   = ~last_nx;
    end else if (tx_valid) begin
      load_take = 1'b1;
      load_din  = tx_bit;
    end
  end

  // TX FSM. Contamination matters only while ACTIVE; in IDLE and LOST we
  // send recessive, and other nodes may legitimately drive the bus dominant.
  always_comb begin
    state_nx    = state;
    din_nx      = din;
    tx_ready_nx = 1'b0;
    arb_lost_nx = 1'b0;
    bit_err_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          din_nx      = load_din;
          tx_ready_nx = load_take;
          state_nx    = S_ACTIVE;
        end else begin
          din_nx = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (cntmn && arb_en && din) begin
          arb_lost_nx = 1'b1;
          din_nx      = 1'b1;
          state_nx    = S_LOST;
        end else if (cntmn) begin
          bit_err_nx = 1'b1;
          din_nx     = 1'b1;
          state_nx   = S_IDLE;
        end else begin
          din_nx      = load_din;
          tx_ready_nx = load_take;
          if (!load_stuff && !tx_valid) begin
            state_nx = S_IDLE;
          end
        end
      end
      S_LOST: begin
        din_nx = 1'b1;
        if (!tx_valid) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        din_nx   = 1'b1;
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers. Pulses clear on every cycle that is not a sample event.
  always_ff @(posedge GCLK) begin
    if (RES) begin
      cntmn_ready_q <= 1'b0;
      count         <= 3'd0;
      last          <= 1'b1;
      pending       <= 1'b0;
      state         <= S_IDLE;
      din           <= 1'b1;
      tx_ready      <= 1'b0;
      rx_valid      <= 1'b0;
      rx_bit        <= 1'b0;
      stuff_err     <= 1'b0;
      arb_lost      <= 1'b0;
      bit_err       <= 1'b0;
    end else begin
      cntmn_ready_q <= cntmn_ready;
      tx_ready      <= 1'b0;
      rx_valid      <= 1'b0;
      stuff_err     <= 1'b0;
      arb_lost      <= 1'b0;
      bit_err       <= 1'b0;
      if (samp) begin
        count     <= count_nx;
        last      <= last_nx;
        pending   <= pending_nx;
        state     <= state_nx;
        din       <= din_nx;
        tx_ready  <= tx_ready_nx;
        rx_valid  <= rx_valid_nx;
        rx_bit    <= rx_bit_nx;
        stuff_err <= stuff_err_nx;
        arb_lost  <= arb_lost_nx;
        bit_err   <= bit_err_nx;
      end
    end
  end

endmodule

// File: tb/tb_can_bitstuffer.sv
// tb_can_bitstuffer
// Self-checking bench for can_bitstuffer. A slot-level reference model
// tracks the current bus run in a queue and predicts the outputs. They
// are compared on every cycle. Directed scenarios pin the model with
// hand-computed literal values, then randomized traffic exercises it.

module tb_can_bitstuffer;

  localparam int STUFF_LEN = 5;
  localparam int M_IDLE    = 0;
  localparam int M_ACTIVE  = 1;
  localparam int M_LOST    = 2;

  logic GCLK        = 1'b0;
  logic RES         = 1'b1;
  logic dout        = 1'b1;
  logic cntmn       = 1'b0;
  logic cntmn_ready = 1'b0;
  logic stuff_en    = 1'b1;
  logic arb_en      = 1'b0;
  logic tx_valid    = 1'b0;
  logic tx_bit      = 1'b1;
  logic din, tx_ready, tx_busy, rx_valid, rx_bit, stuff_err, arb_lost, bit_err;

  int total = 0;
  int bad   = 0;
  bit compare_on = 1'b0;
  bit loopback   = 1'b0;

  // values captured one cycle after a directed sample event
  logic s_din, s_tx_ready, s_tx_busy, s_rx_valid, s_rx_bit, s_stuff_err, s_arb_lost, s_bit_err;

  // reference model state
  bit m_din, m_tx_ready, m_rx_valid, m_rx_bit, m_stuff_err, m_arb_lost, m_bit_err;
  bit m_ready_q;
  bit m_expect_stuff;
  int m_mode;
  bit run [$];

  can_bitstuffer #(.STUFF_LEN(STUFF_LEN)) dut (
    .GCLK(GCLK), .RES(RES), .dout(dout), .cntmn(cntmn), .cntmn_ready(cntmn_ready),
    .din(din), .stuff_en(stuff_en), .arb_en(arb_en), .tx_valid(tx_valid), .tx_bit(tx_bit),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .stuff_err(stuff_err), .arb_lost(arb_lost), .bit_err(bit_err)
  );

  always #5 GCLK = ~GCLK;

  // Pick the next bit to put on the bus, given the updated run state.
  function automatic void modelLoad(output bit stuffed);
    stuffed = 1'b0;
    if (stuff_en && m_expect_stuff) begin
      m_din   = ~run[$];
      stuffed = 1'b1;
    end else if (tx_valid) begin
      m_din      = tx_bit;
      m_tx_ready = 1'b1;
    end else begin
      m_din = 1'b1;
    end
  endfunction

  // What one sample event must do, according to the bit-stuffing rules.
  function automatic void modelSlot();
    bit stuffed;
    if (!stuff_en) begin
      run.delete();
      m_expect_stuff = 1'b0;
      m_rx_valid = 1'b1;
      m_rx_bit   = dout;
    end else if (m_expect_stuff) begin
      if (dout == run[$]) m_stuff_err = 1'b1;
      run.delete();
      run.push_back(dout);
      m_expect_stuff = 1'b0;
    end else begin
      m_rx_valid = 1'b1;
      m_rx_bit   = dout;
      if (run.size() == 0 || run[$] != dout) run.delete();
      run.push_back(dout);
      m_expect_stuff = (run.size() == STUFF_LEN);
    end
    case (m_mode)
      M_IDLE: begin
        if (tx_valid) begin
          modelLoad(stuffed);
          m_mode = M_ACTIVE;
        end else begin
          m_din = 1'b1;
        end
      end
      M_ACTIVE: begin
        if (cntmn && arb_en && m_din) begin
          m_arb_lost = 1'b1;
          m_din = 1'b1;
          m_mode = M_LOST;
        end else if (cntmn) begin
          m_bit_err = 1'b1;
          m_din = 1'b1;
          m_mode = M_IDLE;
        end else begin
          modelLoad(stuffed);
          if (!stuffed && !tx_valid) m_mode = M_IDLE;
        end
      end
      default: begin
        m_din = 1'b1;
        if (!tx_valid) m_mode = M_IDLE;
      end
    endcase
  endfunction

  // Advance the model on every rising edge, in step with the clock.
  always @(posedge GCLK) begin
    m_tx_ready  = 1'b0;
    m_rx_valid  = 1'b0;
    m_stuff_err = 1'b0;
    m_arb_lost  = 1'b0;
    m_bit_err   = 1'b0;
    if (RES) begin
      m_ready_q = 1'b0;
      m_din = 1'b1;
      m_rx_bit = 1'b0;
      m_expect_stuff = 1'b0;
      m_mode = M_IDLE;
      run.delete();
    end else begin
      if (cntmn_ready && !m_ready_q) modelSlot();
      m_ready_q = cntmn_ready;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge GCLK) begin
    if (compare_on) begin
      total++;
      if ({din, tx_ready, tx_busy, rx_valid, stuff_err, arb_lost, bit_err} !==
          {m_din, m_tx_ready, (m_mode != M_IDLE), m_rx_valid, m_stuff_err, m_arb_lost, m_bit_err} ||
          (m_rx_valid && rx_bit !== m_rx_bit)) begin
        bad++;
        $display("[TB] FAIL cycle_cmp t=%0t din/rdy/busy/rxv/serr/arb/berr/rxb got=%b%b%b%b%b%b%b%b want=%b%b%b%b%b%b%b%b",
                 $time, din, tx_ready, tx_busy, rx_valid, stuff_err, arb_lost, bit_err, rx_bit,
                 m_din, m_tx_ready, (m_mode != M_IDLE), m_rx_valid, m_stuff_err, m_arb_lost, m_bit_err, m_rx_bit);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  // One sampler slot: raise cntmn_ready with the bus values, then capture
  // the registered outputs one cycle later.
  task automatic applyStimulus(input bit d, input bit c);
    @(negedge GCLK);
    cntmn_ready = 1'b1;
    dout  = loopback ? din : d;
    cntmn = loopback ? 1'b0 : c;
    @(negedge GCLK);
    s_din = din; s_tx_ready = tx_ready; s_tx_busy = tx_busy; s_rx_valid = rx_valid;
    s_rx_bit = rx_bit; s_stuff_err = stuff_err; s_arb_lost = arb_lost; s_bit_err = bit_err;
    cntmn_ready = 1'b0;
    @(negedge GCLK);
  endtask

  task automatic doReset(input int cycles);
    @(negedge GCLK);
    RES = 1'b1;
    cntmn_ready = 1'b0;
    repeat (cycles) @(negedge GCLK);
    RES = 1'b0;
  endtask

  initial begin
    bit exp_lb_din [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit exp_lb_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int sent, zeros, serrs, readies;

    repeat (3) @(negedge GCLK);
    RES = 1'b0;
    compare_on = 1'b1;

    // reset mid-stream discards the partial run
    stuff_en = 1'b1; tx_valid = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0);
    @(negedge GCLK);
    RES = 1'b1;
    repeat (3) @(negedge GCLK);
    checkOutput("rst_din", din, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_pulses", {tx_ready, rx_valid, stuff_err, arb_lost, bit_err}, 0);
    RES = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("rst_run_rxv", s_rx_valid, 1);
      checkOutput("rst_run_serr", s_stuff_err, 0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_6th_serr", s_stuff_err, 1);
    checkOutput("rst_6th_rxv", s_rx_valid, 0);

    // TX stuffing in loopback, six dominant data bits
    doReset(2);
    loopback = 1'b1; tx_bit = 1'b0; tx_valid = 1'b1;
    sent = 0; zeros = 0; serrs = 0; readies = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("lb_din%0d", i), s_din, exp_lb_din[i]);
      checkOutput($sformatf("lb_rdy%0d", i), s_tx_ready, exp_lb_rdy[i]);
      if (s_tx_ready) begin sent++; readies++; end
      if (s_rx_valid && !s_rx_bit) zeros++;
      if (s_stuff_err) serrs++;
      tx_valid = (sent < 6);
    end
    checkOutput("lb_ready_count", readies, 6);
    checkOutput("lb_rx_zeros", zeros, 6);
    checkOutput("lb_stuff_err", serrs, 0);
    loopback = 1'b0; tx_valid = 1'b0;

    // RX stuff error: six recessive bits with no TX
    doReset(2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("rxs_rxv", s_rx_valid, 1);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("rxs_serr", s_stuff_err, 1);
    checkOutput("rxs_no_rxv", s_rx_valid, 0);

    // arbitration loss
    doReset(2);
    arb_en = 1'b1; tx_valid = 1'b1; tx_bit = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("arb_first_rdy", s_tx_ready, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("arb_lost", s_arb_lost, 1);
    checkOutput("arb_din", s_din, 1);
    checkOutput("arb_no_rdy", s_tx_ready, 0);
    checkOutput("arb_busy", s_tx_busy, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("lost_hold_busy", s_tx_busy, 1);
    checkOutput("lost_no_pulse", {s_tx_ready, s_arb_lost, s_bit_err}, 0);
    tx_valid = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("lost_to_idle", s_tx_busy, 0);
    arb_en = 1'b0;

    // bit error outside arbitration
    doReset(2);
    tx_valid = 1'b1; tx_bit = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("be_active_din", s_din, 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("be_pulse", s_bit_err, 1);
    checkOutput("be_din", s_din, 1);
    checkOutput("be_busy", s_tx_busy, 0);
    tx_valid = 1'b0;

    // fixed-form field, then stuffing re-enabled restarts the run
    doReset(2);
    stuff_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("ff_rx", {s_rx_valid, s_rx_bit, s_stuff_err, s_din}, 4'b1001);
    end
    stuff_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("ff_re_rxv", {s_rx_valid, s_stuff_err}, 2'b10);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("ff_re_serr", {s_rx_valid, s_stuff_err}, 2'b01);

    // randomized traffic, checked by the per-cycle model comparison
    doReset(2);
    for (int s = 0; s < 1500; s++) begin
      int kind;
      if ($urandom_range(0, 199) == 0) doReset($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) stuff_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) arb_en = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) tx_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) tx_bit = $urandom_range(0, 1);
      @(negedge GCLK);
      kind = $urandom_range(0, 9);
      cntmn_ready = 1'b1;
      if (kind <= 6) begin
        dout = din; cntmn = 1'b0;
      end else if (kind == 7) begin
        dout = ~din; cntmn = 1'b1;
      end else begin
        dout = $urandom_range(0, 1); cntmn = $urandom_range(0, 1);
      end
      repeat ($urandom_range(1, 3)) @(negedge GCLK);
      cntmn_ready = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge GCLK);
    end

    @(negedge GCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
